// File: rtl/load_store_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_store_unit : single-outstanding load/store sequencer driving a
//                   fixed-latency data memory. Optional LSU_ALIGN_CHECK_EN
//                   adds misalignment errors on top of illegal-type errors.
// Revision        : 1.0  initial release
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int DM_LAT = 6,
  parameter int ADDR_W = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        dm_w,
  output logic [2:0]  dm_type,
  output logic [31:0] dm_a,
  output logic [31:0] dm_wd,
  input  logic [31:0] dm_rd
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam logic [3:0] CNT_LOAD = 4'(DM_LAT - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        type_ok;
  logic        misaligned;
  logic        req_err;
  logic [31:0] addr_trunc;
  logic        unused_addr_bits;

  // Only the low ADDR_W bits reach memory; the rest are intentionally dropped.
  assign unused_addr_bits = ^req_addr;

  always_comb begin
    addr_trunc = '0;
    addr_trunc[ADDR_W-1:0] = req_addr[ADDR_W-1:0];
  end

  always_comb begin
    type_ok    = (req_type == 3'b000) || req_type[2];
    misaligned = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    misaligned = ((req_type == 3'b000) && (req_addr[1:0] != 2'b00)) ||
                 ((req_type[2:1] == 2'b10) && req_addr[0]);
`endif
    req_err    = !type_ok || misaligned;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    type_d  = type_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          type_d  = req_type;
          addr_d  = addr_trunc;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = req_err;
          // Erroring requests skip the memory entirely.
          state_d = req_err ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          rdata_d = we_q ? 32'd0 : dm_rd;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      type_q  <= 3'b000;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dm_w      = we_q && ((state_q == S_ISSUE) || (state_q == S_WAIT));
  assign dm_type   = type_q;
  assign dm_a      = addr_q;
  assign dm_wd     = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_load_store_unit : directed table + random transactions against a
//                      transaction-level model of the load/store unit.
// Revision           : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int DM_LAT = 6;
  localparam int ADDR_W = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        dm_w;
  logic [2:0]  dm_type;
  logic [31:0] dm_a, dm_wd, dm_rd;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.DM_LAT(DM_LAT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dm_w(dm_w), .dm_type(dm_type), .dm_a(dm_a),
    .dm_wd(dm_wd), .dm_rd(dm_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dmrd;
    int          hold;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_dmw;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference rules: legal codes, alignment, latency and data per access.
  function automatic logic model_err(input logic [2:0] typ, input logic [31:0] addr);
    logic legal_type, mis;
    legal_type = (typ == 3'b000) || (typ == 3'b100) || (typ == 3'b101) ||
                 (typ == 3'b110) || (typ == 3'b111);
    mis = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    if (typ == 3'b000 && (addr % 4) != 0) mis = 1'b1;
    if ((typ == 3'b100 || typ == 3'b101) && (addr % 2) != 0) mis = 1'b1;
`endif
    return !legal_type || mis;
  endfunction

  task automatic run_txn(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] dmrd, input int hold,
                         input logic legal,
                         output logic got_err, output logic [31:0] got_rdata,
                         output int lat, output int dmw_cycles);
    int guard;
    logic [31:0] exp_a;
    exp_a = addr % (32'd1 << ADDR_W);
    guard = 0;
    while (!req_ready && guard < 50) begin tick(); guard++; end
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_type = typ; req_addr = addr; req_wdata = wdata;
    dm_rd = dmrd;
    tick();
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 1; dmw_cycles = 0;
    while (!rsp_valid && lat < 40) begin
      if (dm_w) dmw_cycles++;
      if (legal) begin
        chk("dm_a", dm_a, exp_a);
        chk("dm_type", {29'd0, dm_type}, {29'd0, typ});
        chk("dm_wd", dm_wd, wdata);
      end
      tick();
      lat++;
    end
    if (!rsp_valid) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      got_err = 1'bx; got_rdata = 'x;
      reset = 1'b1; tick(); reset = 1'b0;
      return;
    end
    chk("dm_w_in_resp", {31'd0, dm_w}, 32'd0);
    got_err = rsp_err; got_rdata = rsp_rdata;
    // Backpressure: keep a competing request asserted, it must not be taken.
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_type = 3'b000; req_addr = 32'd0;
      tick();
      chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rdata", rsp_rdata, got_rdata);
      chk("hold_err", {31'd0, rsp_err}, {31'd0, got_err});
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("retire_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("retire_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  vec_t vecs[5];

  initial begin
    logic        g_err;
    logic [31:0] g_rdata;
    int          g_lat, g_dmw;
    logic        e_err;
    int          seen;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_type = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0; dm_rd = 32'd0;
    tick(); tick();
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_dm_w", {31'd0, dm_w}, 32'd0);
    chk("rst_dm_type", {29'd0, dm_type}, 32'd0);
    chk("rst_dm_a", dm_a, 32'd0);
    chk("rst_dm_wd", dm_wd, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    reset = 1'b0;

    vecs[0] = '{1'b0, 3'b000, 32'h8, 32'h0, 32'h12345678, 0, 1'b0, 32'h12345678, DM_LAT+2, 0};
    vecs[1] = '{1'b1, 3'b110, 32'h5, 32'hAB, 32'hDEADBEEF, 0, 1'b0, 32'h0, DM_LAT+2, DM_LAT+1};
`ifdef LSU_ALIGN_CHECK_EN
    vecs[2] = '{1'b0, 3'b100, 32'h3, 32'h0, 32'hCAFEF00D, 0, 1'b1, 32'h0, 1, 0};
`else
    vecs[2] = '{1'b0, 3'b100, 32'h3, 32'h0, 32'hCAFEF00D, 0, 1'b0, 32'hCAFEF00D, DM_LAT+2, 0};
`endif
    vecs[3] = '{1'b1, 3'b010, 32'h10, 32'h55, 32'h11111111, 0, 1'b1, 32'h0, 1, 0};
    vecs[4] = '{1'b0, 3'b111, 32'h7F, 32'h0, 32'hA5A5_5A5A, 5, 1'b0, 32'hA5A5_5A5A, DM_LAT+2, 0};

    for (int v = 0; v < 5; v++) begin
      run_txn(vecs[v].we, vecs[v].typ, vecs[v].addr, vecs[v].wdata, vecs[v].dmrd,
              vecs[v].hold, !vecs[v].exp_err, g_err, g_rdata, g_lat, g_dmw);
      chk($sformatf("vec%0d_err", v), {31'd0, g_err}, {31'd0, vecs[v].exp_err});
      chk($sformatf("vec%0d_rdata", v), g_rdata, vecs[v].exp_rdata);
      chk($sformatf("vec%0d_lat", v), 32'(g_lat), 32'(vecs[v].exp_lat));
      chk($sformatf("vec%0d_dmw", v), 32'(g_dmw), 32'(vecs[v].exp_dmw));
    end

    // Reset in the middle of a store's WAIT phase abandons it silently.
    req_valid = 1'b1; req_we = 1'b1; req_type = 3'b000; req_addr = 32'h20;
    req_wdata = 32'h77;
    tick(); req_valid = 1'b0;
    tick(); tick(); tick();
    chk("mid_store_dm_w", {31'd0, dm_w}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstwait_dm_w", {31'd0, dm_w}, 32'd0);
    chk("rstwait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rstwait_req_ready", {31'd0, req_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < DM_LAT + 6; i++) begin
      if (rsp_valid) seen++;
      tick();
    end
    chk("rstwait_no_rsp", 32'(seen), 32'd0);

    for (int n = 0; n < 40; n++) begin
      logic        r_we;
      logic [2:0]  r_typ;
      logic [31:0] r_addr, r_wd, r_rd;
      int          r_hold;
      r_we   = 1'($urandom);
      r_typ  = 3'($urandom);
      r_addr = $urandom;
      r_wd   = $urandom;
      r_rd   = $urandom;
      r_hold = $urandom_range(0, 3);
      e_err  = model_err(r_typ, r_addr);
      run_txn(r_we, r_typ, r_addr, r_wd, r_rd, r_hold, !e_err, g_err, g_rdata, g_lat, g_dmw);
      chk("rnd_err", {31'd0, g_err}, {31'd0, e_err});
      chk("rnd_rdata", g_rdata, (e_err || r_we) ? 32'd0 : r_rd);
      chk("rnd_lat", 32'(g_lat), e_err ? 32'd1 : 32'(DM_LAT + 2));
      chk("rnd_dmw", 32'(g_dmw), (r_we && !e_err) ? 32'(DM_LAT + 1) : 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
